// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back stage: result-source select
// encodings and load-size encodings.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_DM   = 2'd1,
    WB_SEL_LINK = 2'd2,
    WB_SEL_IMM  = 2'd3
  } wb_sel_e;

  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_FULL = 2'd2;
  localparam logic [1:0] LD_RSVD = 2'd3;

endpackage

// File: rtl/write_back_stage_load_extend.sv
// Combinational sub-word load lane select with sign/zero extension, plus the
// raw alignment check for the requested load size.
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] dm_data,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic [DATA_W-1:0] ext_data,
  output logic              mis
);

  localparam int N_BYTES  = DATA_W / 8;
  localparam int N_HALVES = DATA_W / 16;

  logic [7:0]  byte_lane [N_BYTES];
  logic [15:0] half_lane [N_HALVES];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < N_BYTES; gi++) begin : g_byte
      assign byte_lane[gi] = dm_data[8*gi +: 8];
    end
    for (gi = 0; gi < N_HALVES; gi++) begin : g_half
      assign half_lane[gi] = dm_data[16*gi +: 16];
    end
  endgenerate

  // Half lanes are indexed by the offset with its low bit dropped.
  assign sel_byte = byte_lane[byte_off];
  assign sel_half = half_lane[byte_off[OFF_W-1:1]];

  always_comb begin
    ext_data = dm_data;
    mis      = 1'b0;
    case (ld_size)
      LD_BYTE: begin
        ext_data = {{(DATA_W-8){~ld_unsigned & sel_byte[7]}}, sel_byte};
      end
      LD_HALF: begin
        ext_data = {{(DATA_W-16){~ld_unsigned & sel_half[15]}}, sel_half};
        mis      = byte_off[0];
      end
      LD_FULL, LD_RSVD: begin
        ext_data = dm_data;
        mis      = |byte_off;
      end
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register: source select, load extension, x0/misalign write
// suppression, stall/flush. Optional retire counter under WB_RETIRE_CNT_EN.
module write_back_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OFF_W      = $clog2(DATA_W/8),
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [1:0]            wb_sel,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  input  logic [OFF_W-1:0]      byte_off,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic [DATA_W-1:0]     alu_data_out,
  input  logic [DATA_W-1:0]     dm_data_out,
  input  logic [DATA_W-1:0]     link_addr,
  input  logic [DATA_W-1:0]     imm_data,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic                  wb_we,
  output logic                  wb_valid,
  output logic                  misalign_err,
  output logic [CNT_W-1:0]      retire_count
);

  logic [DATA_W-1:0]     ext_data;
  logic                  ext_mis;
  logic [DATA_W-1:0]     data_next;
  logic                  mis_next;
  logic                  we_next;

  logic [DATA_W-1:0]     data_reg;
  logic [REG_ADDR_W-1:0] reg_reg;
  logic                  we_reg;
  logic                  valid_reg;
  logic                  mis_reg;

  load_extend #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_extend (
    .dm_data     (dm_data_out),
    .byte_off    (byte_off),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .ext_data    (ext_data),
    .mis         (ext_mis)
  );

  always_comb begin
    data_next = alu_data_out;
    mis_next  = 1'b0;
    case (wb_sel_e'(wb_sel))
      WB_SEL_ALU:  data_next = alu_data_out;
      WB_SEL_DM: begin
        data_next = ext_data;
        mis_next  = in_valid & ext_mis;
      end
      WB_SEL_LINK: data_next = link_addr;
      WB_SEL_IMM:  data_next = imm_data;
      default:     data_next = alu_data_out;
    endcase
    // A misaligned load still retires but must never reach the register file.
    we_next = in_valid & reg_write & (dest_reg != '0) & ~mis_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg  <= '0;
      reg_reg   <= '0;
      we_reg    <= 1'b0;
      valid_reg <= 1'b0;
      mis_reg   <= 1'b0;
    end else if (flush) begin
      we_reg    <= 1'b0;
      valid_reg <= 1'b0;
      mis_reg   <= 1'b0;
    end else if (!stall) begin
      data_reg  <= data_next;
      reg_reg   <= dest_reg;
      we_reg    <= we_next;
      valid_reg <= in_valid;
      mis_reg   <= mis_next;
    end
  end

  assign wb_data      = data_reg;
  assign wb_reg       = reg_reg;
  assign wb_we        = we_reg;
  assign wb_valid     = valid_reg;
  assign misalign_err = mis_reg;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (!flush && !stall && in_valid) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign retire_count = cnt_reg;
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: directed vectors push expected
// outputs; a monitor pops and compares one vector per clock.
module tb_write_back_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [1:0]  wb_sel, ld_size;
  logic        ld_unsigned, reg_write;
  logic [1:0]  byte_off;
  logic [4:0]  dest_reg;
  logic [31:0] alu_data_out, dm_data_out, link_addr, imm_data;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_we, wb_valid, misalign_err;
  logic [3:0]  retire_count;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [4:0]  rg;
    logic        we;
    logic        valid;
    logic        mis;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [3:0]  mcnt = '0;
  logic [31:0] prev_data;
  logic [4:0]  prev_reg;

  write_back_stage #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .stall        (stall),
    .flush        (flush),
    .wb_sel       (wb_sel),
    .ld_size      (ld_size),
    .ld_unsigned  (ld_unsigned),
    .byte_off     (byte_off),
    .reg_write    (reg_write),
    .dest_reg     (dest_reg),
    .alu_data_out (alu_data_out),
    .dm_data_out  (dm_data_out),
    .link_addr    (link_addr),
    .imm_data     (imm_data),
    .wb_data      (wb_data),
    .wb_reg       (wb_reg),
    .wb_we        (wb_we),
    .wb_valid     (wb_valid),
    .misalign_err (misalign_err),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    reset = 0; in_valid = 0; stall = 0; flush = 0;
    wb_sel = 0; ld_size = 0; ld_unsigned = 0; byte_off = 0;
    reg_write = 0; dest_reg = 0;
    alu_data_out = 0; dm_data_out = 0; link_addr = 0; imm_data = 0;
  endtask

  task automatic op(input logic v, input logic [1:0] sel, input logic [1:0] sz,
                    input logic uns, input logic [1:0] off, input logic rw,
                    input logic [4:0] rd);
    in_valid = v; wb_sel = sel; ld_size = sz; ld_unsigned = uns;
    byte_off = off; reg_write = rw; dest_reg = rd;
  endtask

  // Inputs are already driven; queue the expectation, let one posedge pass,
  // and return on the following negedge so the next vector changes inputs there.
  task automatic step(input string name, input logic [31:0] d, input logic [4:0] r,
                      input logic we, input logic v, input logic m);
    exp_t e;
`ifdef WB_RETIRE_CNT_EN
    if (reset) mcnt = '0;
    else if (!flush && !stall && in_valid) mcnt = mcnt + 4'd1;
`endif
    e.name = name; e.data = d; e.rg = r; e.we = we; e.valid = v; e.mis = m; e.cnt = mcnt;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++;
        if (wb_data !== e.data || wb_reg !== e.rg || wb_we !== e.we ||
            wb_valid !== e.valid || misalign_err !== e.mis || retire_count !== e.cnt) begin
          n_fail++;
          $display("FAIL %s: got data=%h reg=%0d we=%b valid=%b mis=%b cnt=%0d, expected data=%h reg=%0d we=%b valid=%b mis=%b cnt=%0d",
                   e.name, wb_data, wb_reg, wb_we, wb_valid, misalign_err, retire_count,
                   e.data, e.rg, e.we, e.valid, e.mis, e.cnt);
        end else begin
          $display("vec %0d %s: data=%h reg=%0d we=%b valid=%b mis=%b cnt=%0d",
                   n_vec, e.name, wb_data, wb_reg, wb_we, wb_valid, misalign_err, retire_count);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    set_idle();
    reset = 1;
    step("reset", 32'h0, 5'd0, 0, 0, 0);
    reset = 0;

    op(1, WB_SEL_ALU, LD_BYTE, 0, 0, 1, 5); alu_data_out = 32'h0000_1234;
    step("alu_r5", 32'h0000_1234, 5'd5, 1, 1, 0);

    dm_data_out = 32'h80FF_7F01;
    op(1, WB_SEL_DM, LD_BYTE, 0, 3, 1, 6);  step("lb_off3",  32'hFFFF_FF80, 5'd6, 1, 1, 0);
    op(1, WB_SEL_DM, LD_HALF, 1, 2, 1, 7);  step("lhu_off2", 32'h0000_80FF, 5'd7, 1, 1, 0);
    op(1, WB_SEL_DM, LD_BYTE, 0, 1, 1, 8);  step("lb_off1",  32'h0000_007F, 5'd8, 1, 1, 0);
    op(1, WB_SEL_DM, LD_BYTE, 1, 2, 1, 9);  step("lbu_off2", 32'h0000_00FF, 5'd9, 1, 1, 0);
    op(1, WB_SEL_DM, LD_BYTE, 0, 2, 1, 10); step("lb_off2",  32'hFFFF_FFFF, 5'd10, 1, 1, 0);
    op(1, WB_SEL_DM, LD_HALF, 0, 2, 1, 11); step("lh_off2",  32'hFFFF_80FF, 5'd11, 1, 1, 0);
    op(1, WB_SEL_DM, LD_HALF, 0, 0, 1, 12); step("lh_off0",  32'h0000_7F01, 5'd12, 1, 1, 0);

    op(1, WB_SEL_ALU, LD_BYTE, 0, 0, 1, 0);
    step("x0_suppress", 32'h0000_1234, 5'd0, 0, 1, 0);

    op(1, WB_SEL_DM, LD_HALF, 1, 1, 1, 13); step("lh_misalign",   32'h0000_7F01, 5'd13, 0, 1, 1);
    op(1, WB_SEL_DM, LD_FULL, 0, 0, 1, 14); step("lw_aligned",    32'h80FF_7F01, 5'd14, 1, 1, 0);
    op(1, WB_SEL_DM, LD_FULL, 0, 2, 1, 15); step("lw_misalign",   32'h80FF_7F01, 5'd15, 0, 1, 1);
    op(1, WB_SEL_DM, LD_RSVD, 0, 0, 1, 16); step("ld_rsvd_full",  32'h80FF_7F01, 5'd16, 1, 1, 0);
    op(0, WB_SEL_DM, LD_HALF, 0, 1, 1, 17); step("invalid_dm",    32'h0000_7F01, 5'd17, 0, 0, 0);

    link_addr = 32'h0040_0010; imm_data = 32'hFFFF_F000;
    op(1, WB_SEL_LINK, LD_HALF, 0, 1, 1, 18); step("link_src", 32'h0040_0010, 5'd18, 1, 1, 0);
    op(1, WB_SEL_IMM,  LD_FULL, 0, 3, 1, 19); step("imm_src",  32'hFFFF_F000, 5'd19, 1, 1, 0);

    op(1, WB_SEL_ALU, LD_BYTE, 0, 0, 1, 3); alu_data_out = 32'h0000_00AA;
    step("alu_r3", 32'h0000_00AA, 5'd3, 1, 1, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu_data_out = 32'h55 + i; dest_reg = 5'd9 + 5'(i);
      step("stall_hold", 32'h0000_00AA, 5'd3, 1, 1, 0);
    end
    flush = 1;
    step("stall_flush", 32'h0000_00AA, 5'd3, 0, 0, 0);
    stall = 0; flush = 0;

    op(1, WB_SEL_DM, LD_HALF, 0, 3, 1, 20); step("lh_off3_mis", 32'hFFFF_80FF, 5'd20, 0, 1, 1);
    flush = 1; op(1, WB_SEL_ALU, LD_BYTE, 0, 0, 1, 21); alu_data_out = 32'h55;
    step("flush_clears_mis", 32'hFFFF_80FF, 5'd20, 0, 0, 0);
    flush = 0; op(1, WB_SEL_ALU, LD_BYTE, 0, 0, 1, 22); alu_data_out = 32'h77;
    step("alu_r22", 32'h0000_0077, 5'd22, 1, 1, 0);
    stall = 1; reset = 1;
    step("reset_in_stall", 32'h0, 5'd0, 0, 0, 0);

    // Retire-count run: 17 valid captures mixed with 2 flushes and 2 stalls.
    set_idle();
    reset = 1;
    step("cnt_reset", 32'h0, 5'd0, 0, 0, 0);
    reset = 0;
    prev_data = '0; prev_reg = '0;
    for (int i = 0; i < 21; i++) begin
      op(1, WB_SEL_ALU, LD_BYTE, 0, 0, 1, 5'((i % 30) + 1));
      alu_data_out = 32'h100 + i;
      flush = (i == 4 || i == 12);
      stall = (i == 8 || i == 16);
      if (flush) begin
        step("cnt_flush", prev_data, prev_reg, 0, 0, 0);
      end else if (stall) begin
        step("cnt_stall", prev_data, prev_reg, 1, 1, 0);
      end else begin
        step("cnt_capture", alu_data_out, dest_reg, 1, 1, 0);
        prev_data = alu_data_out; prev_reg = dest_reg;
      end
    end
    set_idle();
    step("cnt_idle", 32'h0, 5'd0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending vectors, expected 0", sb.size());
    end

    n_vec++;
`ifdef WB_RETIRE_CNT_EN
    if (retire_count !== 4'd1) begin
      n_fail++;
      $display("FAIL retire_wrap: got %0d, expected 1", retire_count);
    end
`else
    if (retire_count !== 4'd0) begin
      n_fail++;
      $display("FAIL retire_tied: got %0d, expected 0", retire_count);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
